// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bundle: decoded ID fields in, registered EX fields, pipeline enables
// and the bubble counter out. The master drives ID, the slave is the stage register.
interface idex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_usesRt;
    logic [DATA_W-1:0] id_read1, id_read2, id_imm, id_pc4;
    logic              id_regWr, id_memRead, id_memWr, id_memToReg, id_aluSrc, id_regDst;
    logic [2:0]        id_aluOp;
    logic              flush, freeze;

    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_read1, ex_read2, ex_imm, ex_pc4;
    logic              ex_regWr, ex_memRead, ex_memWr, ex_memToReg, ex_aluSrc, ex_regDst;
    logic [2:0]        ex_aluOp;
    logic              pc_write, ifid_write;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs, id_rt, id_rd, id_usesRt, id_read1, id_read2, id_imm, id_pc4,
               id_regWr, id_memRead, id_memWr, id_memToReg, id_aluSrc, id_regDst,
               id_aluOp, flush, freeze,
        input  ex_rs, ex_rt, ex_rd, ex_read1, ex_read2, ex_imm, ex_pc4,
               ex_regWr, ex_memRead, ex_memWr, ex_memToReg, ex_aluSrc, ex_regDst,
               ex_aluOp, pc_write, ifid_write, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_usesRt, id_read1, id_read2, id_imm, id_pc4,
               id_regWr, id_memRead, id_memWr, id_memToReg, id_aluSrc, id_regDst,
               id_aluOp, flush, freeze,
        output ex_rs, ex_rt, ex_rd, ex_read1, ex_read2, ex_imm, ex_pc4,
               ex_regWr, ex_memRead, ex_memWr, ex_memToReg, ex_aluSrc, ex_regDst,
               ex_aluOp, pc_write, ifid_write, stall_cnt
    );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, global freeze
// and a saturating count of inserted load-use bubbles.
module idex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    idex_stage_reg_if.slave    bus
);
    typedef struct packed {
        logic [REG_AW-1:0] rs, rt, rd;
        logic [DATA_W-1:0] read1, read2, imm, pc4;
        logic              regWr, memRead, memWr, memToReg, aluSrc, regDst;
        logic [2:0]        aluOp;
    } stage_t;

    stage_t           r_ex;
    stage_t           w_id;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hazard;
    logic             w_enable;

    assign w_id = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                    read1: bus.id_read1, read2: bus.id_read2,
                    imm: bus.id_imm, pc4: bus.id_pc4,
                    regWr: bus.id_regWr, memRead: bus.id_memRead,
                    memWr: bus.id_memWr, memToReg: bus.id_memToReg,
                    aluSrc: bus.id_aluSrc, regDst: bus.id_regDst,
                    aluOp: bus.id_aluOp};

    // A load in EX whose target is read by ID cannot be forwarded yet; $0 never counts.
    assign w_hazard = r_ex.memRead && (r_ex.rt != '0) &&
                      ((r_ex.rt == bus.id_rs) || (bus.id_usesRt && (r_ex.rt == bus.id_rt)));

    assign w_enable = rst || (!bus.freeze && !(w_hazard && !bus.flush));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= '0;
            r_stall_cnt <= '0;
        end else if (!bus.freeze) begin
            if (bus.flush) begin
                r_ex <= '0;
            end else if (w_hazard) begin
                r_ex <= '0;
                if (r_stall_cnt != '1)
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_ex <= w_id;
            end
        end
    end

    assign bus.ex_rs       = r_ex.rs;
    assign bus.ex_rt       = r_ex.rt;
    assign bus.ex_rd       = r_ex.rd;
    assign bus.ex_read1    = r_ex.read1;
    assign bus.ex_read2    = r_ex.read2;
    assign bus.ex_imm      = r_ex.imm;
    assign bus.ex_pc4      = r_ex.pc4;
    assign bus.ex_regWr    = r_ex.regWr;
    assign bus.ex_memRead  = r_ex.memRead;
    assign bus.ex_memWr    = r_ex.memWr;
    assign bus.ex_memToReg = r_ex.memToReg;
    assign bus.ex_aluSrc   = r_ex.aluSrc;
    assign bus.ex_regDst   = r_ex.regDst;
    assign bus.ex_aluOp    = r_ex.aluOp;
    assign bus.pc_write    = w_enable;
    assign bus.ifid_write  = w_enable;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed vector table, randomized run against a
// rule-level reference model, and counter saturation on a 4-bit instance.
module tb_idex_stage_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] read1, read2, imm, pc4;
        logic          regWr, memRead, memWr, memToReg, aluSrc, regDst;
        logic [2:0]    aluOp;
    } ex_t;

    typedef struct {
        logic          rst, flush, freeze;
        logic [AW-1:0] rs, rt, rd;
        logic          usesRt, memRead, regWr;
        logic [DW-1:0] read1;
        logic          e_pc;
        logic [AW-1:0] e_rs, e_rt, e_rd;
        logic          e_regWr, e_memRead;
        logic [DW-1:0] e_read1;
        int            e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    idex_stage_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) b1 ();
    idex_stage_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(4))  b2 ();

    idex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
    idex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(b2));

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic ex_t get1();
        ex_t e;
        e = '{rs: b1.ex_rs, rt: b1.ex_rt, rd: b1.ex_rd, read1: b1.ex_read1,
              read2: b1.ex_read2, imm: b1.ex_imm, pc4: b1.ex_pc4,
              regWr: b1.ex_regWr, memRead: b1.ex_memRead, memWr: b1.ex_memWr,
              memToReg: b1.ex_memToReg, aluSrc: b1.ex_aluSrc, regDst: b1.ex_regDst,
              aluOp: b1.ex_aluOp};
        return e;
    endfunction

    task automatic drive1(input ex_t v, input logic uses, input logic r, input logic fl, input logic fz);
        rst1 = r; b1.flush = fl; b1.freeze = fz; b1.id_usesRt = uses;
        b1.id_rs = v.rs; b1.id_rt = v.rt; b1.id_rd = v.rd;
        b1.id_read1 = v.read1; b1.id_read2 = v.read2; b1.id_imm = v.imm; b1.id_pc4 = v.pc4;
        b1.id_regWr = v.regWr; b1.id_memRead = v.memRead; b1.id_memWr = v.memWr;
        b1.id_memToReg = v.memToReg; b1.id_aluSrc = v.aluSrc; b1.id_regDst = v.regDst;
        b1.id_aluOp = v.aluOp;
    endtask

    task automatic drive2(input logic r, input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic mr);
        rst2 = r; b2.flush = 1'b0; b2.freeze = 1'b0; b2.id_usesRt = 1'b1;
        b2.id_rs = rs; b2.id_rt = rt; b2.id_rd = '0;
        b2.id_read1 = '0; b2.id_read2 = '0; b2.id_imm = '0; b2.id_pc4 = '0;
        b2.id_regWr = 1'b1; b2.id_memRead = mr; b2.id_memWr = 1'b0;
        b2.id_memToReg = mr; b2.id_aluSrc = 1'b0; b2.id_regDst = 1'b0; b2.id_aluOp = '0;
    endtask

    function automatic vec_t V(input logic r, fl, fz, input int rs, rt, rd, input logic us, mr, rw,
                               input int rd1, input logic ep, input int ers, ert, erd,
                               input logic erw, emr, input int erd1, input int ecnt);
        vec_t t;
        t.rst = r; t.flush = fl; t.freeze = fz;
        t.rs = AW'(rs); t.rt = AW'(rt); t.rd = AW'(rd);
        t.usesRt = us; t.memRead = mr; t.regWr = rw; t.read1 = DW'(rd1);
        t.e_pc = ep; t.e_rs = AW'(ers); t.e_rt = AW'(ert); t.e_rd = AW'(erd);
        t.e_regWr = erw; t.e_memRead = emr; t.e_read1 = DW'(erd1); t.e_cnt = ecnt;
        return t;
    endfunction

    vec_t tbl[20];
    ex_t  m_ex;
    int   m_cnt;

    initial begin
        ex_t v;
        ex_t got;
        logic hz, en, r, fl, fz, us;

        // rst fl fz rs rt rd us mr rw read1 | pc  rs rt rd rw mr read1 cnt
        tbl[0]  = V(1,0,0, 7,7,0, 1,1,1, 'h55, 1, 0,0,0, 0,0, 0,    0);
        tbl[1]  = V(1,0,0, 7,7,0, 1,1,1, 'h55, 1, 0,0,0, 0,0, 0,    0);
        tbl[2]  = V(0,0,0, 3,4,5, 1,0,1, 'h11, 1, 3,4,5, 1,0, 'h11, 0);
        tbl[3]  = V(0,0,0, 2,8,0, 0,1,1, 'h20, 1, 2,8,0, 1,1, 'h20, 0);
        tbl[4]  = V(0,0,0, 8,9,10,1,0,1, 'h30, 0, 0,0,0, 0,0, 0,    1);
        tbl[5]  = V(0,0,0, 8,9,10,1,0,1, 'h30, 1, 8,9,10,1,0, 'h30, 1);
        tbl[6]  = V(0,0,0, 1,0,0, 0,1,1, 'h40, 1, 1,0,0, 1,1, 'h40, 1);
        tbl[7]  = V(0,0,0, 0,0,3, 1,0,1, 'h50, 1, 0,0,3, 1,0, 'h50, 1);
        tbl[8]  = V(0,0,0, 1,9,0, 0,1,1, 'h60, 1, 1,9,0, 1,1, 'h60, 1);
        tbl[9]  = V(0,0,0, 2,9,4, 0,0,1, 'h70, 1, 2,9,4, 1,0, 'h70, 1);
        tbl[10] = V(0,0,0, 1,9,0, 0,1,1, 'h80, 1, 1,9,0, 1,1, 'h80, 1);
        tbl[11] = V(0,1,0, 9,0,0, 0,0,1, 'h90, 1, 0,0,0, 0,0, 0,    1);
        tbl[12] = V(0,0,0, 1,9,0, 0,1,1, 'hA0, 1, 1,9,0, 1,1, 'hA0, 1);
        tbl[13] = V(0,0,1, 9,0,2, 0,0,1, 'hB0, 0, 1,9,0, 1,1, 'hA0, 1);
        tbl[14] = V(0,0,1, 9,0,2, 0,0,1, 'hB0, 0, 1,9,0, 1,1, 'hA0, 1);
        tbl[15] = V(0,0,1, 9,0,2, 0,0,1, 'hB0, 0, 1,9,0, 1,1, 'hA0, 1);
        tbl[16] = V(0,0,0, 9,0,2, 0,0,1, 'hB0, 0, 0,0,0, 0,0, 0,    2);
        tbl[17] = V(0,0,0, 1,9,0, 0,1,1, 'hC0, 1, 1,9,0, 1,1, 'hC0, 2);
        tbl[18] = V(1,0,0, 9,0,0, 0,0,1, 'hD0, 1, 0,0,0, 0,0, 0,    0);
        tbl[19] = V(0,0,0, 9,0,0, 0,0,1, 'hD0, 1, 9,0,0, 1,0, 'hD0, 0);

        drive2(1'b1, '0, '0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            v = '0;
            v.rs = tbl[i].rs; v.rt = tbl[i].rt; v.rd = tbl[i].rd;
            v.memRead = tbl[i].memRead; v.regWr = tbl[i].regWr; v.read1 = tbl[i].read1;
            drive1(v, tbl[i].usesRt, tbl[i].rst, tbl[i].flush, tbl[i].freeze);
            #1;
            chk($sformatf("vec%0d pc_write", i), 160'(b1.pc_write), 160'(tbl[i].e_pc));
            chk($sformatf("vec%0d ifid_write", i), 160'(b1.ifid_write), 160'(tbl[i].e_pc));
            @(posedge clk); #1;
            chk($sformatf("vec%0d ex_fields", i),
                160'({b1.ex_rs, b1.ex_rt, b1.ex_rd, b1.ex_regWr, b1.ex_memRead, b1.ex_read1}),
                160'({tbl[i].e_rs, tbl[i].e_rt, tbl[i].e_rd, tbl[i].e_regWr, tbl[i].e_memRead, tbl[i].e_read1}));
            chk($sformatf("vec%0d stall_cnt", i), 160'(b1.stall_cnt), 160'(tbl[i].e_cnt));
        end

        // Randomized run; the model applies the edge rules in priority order.
        m_ex = '0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            v.rs = AW'($urandom_range(0, 3)); v.rt = AW'($urandom_range(0, 3));
            v.rd = AW'($urandom_range(0, 31));
            v.read1 = $urandom; v.read2 = $urandom; v.imm = $urandom; v.pc4 = $urandom;
            v.regWr = 1'($urandom); v.memRead = ($urandom_range(0, 1) == 0);
            v.memWr = 1'($urandom); v.memToReg = 1'($urandom); v.aluSrc = 1'($urandom);
            v.regDst = 1'($urandom); v.aluOp = 3'($urandom);
            us = 1'($urandom);
            r  = (n == 0) || ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 9) == 0);
            fz = ($urandom_range(0, 9) == 0);
            drive1(v, us, r, fl, fz);
            #1;
            hz = m_ex.memRead && (m_ex.rt != 0) && (m_ex.rt == v.rs || (us && m_ex.rt == v.rt));
            en = r || (!fz && !(hz && !fl));
            if (n > 0) chk("rand pc_write", 160'(b1.pc_write), 160'(en));
            if (r) begin
                m_ex = '0; m_cnt = 0;
            end else if (fz) begin
                m_ex = m_ex;
            end else if (fl) begin
                m_ex = '0;
            end else if (hz) begin
                m_ex = '0;
                m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            end else begin
                m_ex = v;
            end
            @(posedge clk); #1;
            got = get1();
            chk("rand ex_bundle", 160'(got), 160'(m_ex));
            chk("rand stall_cnt", 160'(b1.stall_cnt), 160'(m_cnt));
        end

        // Saturation on the 4-bit instance: 17 load/consumer pairs.
        drive2(1'b1, '0, '0, 1'b0);
        @(posedge clk); #1;
        chk("sat reset cnt", 160'(b2.stall_cnt), 160'(0));
        for (int k = 1; k <= 17; k++) begin
            drive2(1'b0, 5'd1, 5'd5, 1'b1);
            @(posedge clk); #1;
            drive2(1'b0, 5'd5, 5'd2, 1'b0);
            #1;
            chk($sformatf("sat%0d pc_write", k), 160'(b2.pc_write), 160'(0));
            @(posedge clk); #1;
            chk($sformatf("sat%0d stall_cnt", k), 160'(b2.stall_cnt), 160'((k > 15) ? 15 : k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
